add_sub_pipe: RTL and testbench

//  Parametrised, pipelined integer adder/subtractor for the MIPS datapath. Successor to the flat 32-bit adder.

---
 rtl/mips_alu_pkg.sv | 16 +
 rtl/add_pipe_seg.sv | 36 +++
 rtl/add_sub_pipe.sv | 155 +++++++++++++++
 tb/tb_add_sub_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_alu_pkg.sv
// Shared ALU definitions for the MIPS datapath: operation codes and the flag
// bundle layout {carry, ovf, zero} reused by later ALU blocks.
package mips_alu_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } alu_op_e;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/add_pipe_seg.sv
// One carry-chain segment: SEG-bit add with carry in/out, result registered
// when en is high. Also folds this slice into a running zero flag.
module add_pipe_seg #(
  parameter int SEG = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  input  logic           zin,
  output logic [SEG-1:0] sum,
  output logic           cout,
  output logic           zout
);

  logic [SEG:0] s;

  always_comb begin
    s = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
      zout <= 1'b0;
    end else if (en) begin
      sum  <= s[SEG-1:0];
      cout <= s[SEG];
      zout <= zin & ~|s[SEG-1:0];
    end
  end

endmodule

// File: rtl/add_sub_pipe.sv
// Pipelined ADD/SUB: carry chain split into STAGES registered segments, with
// carry/overflow/zero flags and a pass-through tag; valid/ready on both sides.
module add_sub_pipe
  import mips_alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NSTG = (STAGES < 1) ? 1 : STAGES;
  localparam int SEG  = WIDTH / NSTG;
  localparam int LAST = NSTG - 1;

  if (STAGES < 1 || (WIDTH % NSTG) != 0) begin : g_bad_cfg
    $error("add_sub_pipe: WIDTH (%0d) must be a multiple of STAGES (%0d), STAGES >= 1",
           WIDTH, STAGES);
  end

  logic             adv;
  logic [WIDTH-1:0] bx;
  logic             a_msb;
  logic             b_msb;
  alu_flags_t       flags;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign bx       = (in_op == OP_SUB) ? ~in_b : in_b;

  for (genvar k = 0; k < NSTG; k++) begin : stg
    // Operand bits not yet summed shrink by SEG per stage; the low SEG feed this segment.
    localparam int SRC = WIDTH - k * SEG;

    logic [SRC-1:0]        src_a;
    logic [SRC-1:0]        src_b;
    logic                  vin;
    logic                  cin;
    logic                  zin;
    logic                  ld;
    logic [TAG_W-1:0]      tag_in;
    logic [SEG-1:0]        sum;
    logic                  cout;
    logic                  zout;
    logic                  v;
    logic [TAG_W-1:0]      tag;
    logic [(k+1)*SEG-1:0]  res;

    if (k == 0) begin : g_head
      assign src_a  = in_a;
      assign src_b  = bx;
      assign cin    = in_op;
      assign zin    = 1'b1;
      assign vin    = in_valid;
      assign tag_in = in_tag;
      assign res    = sum;
    end else begin : g_tail
      logic [k*SEG-1:0] lo;

      assign src_a  = stg[k-1].g_rem.a_rem;
      assign src_b  = stg[k-1].g_rem.b_rem;
      assign cin    = stg[k-1].cout;
      assign zin    = stg[k-1].zout;
      assign vin    = stg[k-1].v;
      assign tag_in = stg[k-1].tag;
      assign res    = {sum, lo};

      always_ff @(posedge clk) begin
        if (rst) begin
          lo <= '0;
        end else if (ld) begin
          lo <= stg[k-1].res;
        end
      end
    end

    // Bubbles move the valid bit only, so outputs keep the last real result.
    assign ld = adv && vin;

    add_pipe_seg #(.SEG(SEG)) u_seg (
      .clk  (clk),
      .rst  (rst),
      .en   (ld),
      .a    (src_a[SEG-1:0]),
      .b    (src_b[SEG-1:0]),
      .cin  (cin),
      .zin  (zin),
      .sum  (sum),
      .cout (cout),
      .zout (zout)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        v   <= 1'b0;
        tag <= '0;
      end else begin
        if (adv) v   <= vin;
        if (ld)  tag <= tag_in;
      end
    end

    if (k < LAST) begin : g_rem
      logic [SRC-SEG-1:0] a_rem;
      logic [SRC-SEG-1:0] b_rem;

      always_ff @(posedge clk) begin
        if (ld) begin
          a_rem <= src_a[SRC-1:SEG];
          b_rem <= src_b[SRC-1:SEG];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
    end else if (stg[LAST].ld) begin
      a_msb <= stg[LAST].src_a[SEG-1];
      b_msb <= stg[LAST].src_b[SEG-1];
    end
  end

  always_comb begin
    flags       = '0;
    flags.carry = stg[LAST].cout;
    flags.zero  = stg[LAST].zout;
    flags.ovf   = (a_msb == b_msb) && (out_res[WIDTH-1] != a_msb);
  end

  assign out_valid = stg[LAST].v;
  assign out_res   = stg[LAST].res;
  assign out_tag   = stg[LAST].tag;
  assign out_carry = flags.carry;
  assign out_ovf   = flags.ovf;
  assign out_zero  = flags.zero;

endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe in three shapes (32/4, 32/1, 16/16): directed corner
// vectors, stall and reset sequences, and random traffic against a +/- model.
module tb_add_sub_pipe;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        v;
    logic        z;
    logic [4:0]  tag;
  } exp_t;

  logic clk = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0h, required %0h", nm, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit values.
  function automatic exp_t model(input int w, input logic op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] tag);
    longint unsigned ua, ub, full, m;
    longint          sa, sb, sr, lim;
    exp_t            e;
    m   = 64'd1 << w;
    ua  = 64'(a);
    ub  = 64'(b);
    lim = longint'(m / 2);
    sa  = (ua >= m / 2) ? longint'(ua) - longint'(m) : longint'(ua);
    sb  = (ub >= m / 2) ? longint'(ub) - longint'(m) : longint'(ub);
    if (op) begin
      full = ua - ub;
      e.c  = (ua >= ub);
      sr   = sa - sb;
    end else begin
      full = ua + ub;
      e.c  = (full >= m);
      sr   = sa + sb;
    end
    e.res = 32'(full % m);
    e.v   = (sr >= lim) || (sr < -lim);
    e.z   = (e.res == 32'd0);
    e.tag = tag;
    return e;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int          W    = (g == 2) ? 16 : 32;
    localparam int          S    = (g == 0) ? 4 : ((g == 1) ? 1 : 16);
    localparam int          NOPS = (g == 0) ? 10000 : 2500;
    localparam logic [31:0] MASK = 32'((64'd1 << W) - 1);
    localparam logic [31:0] MSB  = 32'(64'd1 << (W - 1));

    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_op     = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_a      = '0;
    logic [W-1:0] in_b      = '0;
    logic [4:0]   in_tag    = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_res;
    logic         out_carry;
    logic         out_ovf;
    logic         out_zero;
    logic [4:0]   out_tag;
    exp_t         q[$];
    int           outs = 0;

    add_sub_pipe #(.WIDTH(W), .STAGES(S), .TAG_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_carry (out_carry),
      .out_ovf   (out_ovf),
      .out_zero  (out_zero),
      .out_tag   (out_tag)
    );

    function automatic string nm(input string s);
      return $sformatf("c%0d.%s", g, s);
    endfunction

    function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
        0:       return 32'd0;
        1:       return MASK;
        2:       return MSB;
        3:       return MSB - 32'd1;
        default: return $urandom & MASK;
      endcase
    endfunction

    // One cycle: drive at negedge, then score what the next posedge will transfer.
    task automatic step(input logic r, input logic v, input logic op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] t, input logic ordy,
                        input bit use_e, input exp_t e, output bit acc);
      exp_t x;
      @(negedge clk);
      rst       = r;
      in_valid  = v;
      in_op     = op;
      in_a      = a[W-1:0];
      in_b      = b[W-1:0];
      in_tag    = t;
      out_ready = ordy;
      #1;
      acc = !r && in_valid && in_ready;
      if (!r && out_valid && out_ready) begin
        outs++;
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL %s: actual result tag %0d, required no output", nm("extra_out"), out_tag);
        end else begin
          x = q.pop_front();
          check(nm("res"),   32'(out_res),   x.res);
          check(nm("carry"), 32'(out_carry), 32'(x.c));
          check(nm("ovf"),   32'(out_ovf),   32'(x.v));
          check(nm("zero"),  32'(out_zero),  32'(x.z));
          check(nm("tag"),   32'(out_tag),   32'(x.tag));
        end
      end
      if (acc) q.push_back(use_e ? e : model(W, op, a & MASK, b & MASK, t));
    endtask

    task automatic idle(input logic r);
      exp_t d = '{default: '0};
      bit   acc;
      step(r, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, !r, 1'b0, d, acc);
    endtask

    task automatic one_op(input vec_t t);
      exp_t e;
      bit   acc;
      int   n;
      e.res = t.res;
      e.c   = t.c;
      e.v   = t.v;
      e.z   = t.z;
      e.tag = t.tag;
      step(1'b0, 1'b1, t.op, t.a, t.b, t.tag, 1'b1, 1'b1, e, acc);
      check(nm("accept"), 32'(acc), 32'd1);
      n = 0;
      do begin
        idle(1'b0);
        n++;
      end while (!out_valid && n < S + 8);
      check(nm("latency"), 32'(n), 32'(S));
      idle(1'b0);
      check(nm("valid_drop"), 32'(out_valid), 32'd0);
      check(nm("hold_res"),   32'(out_res),   t.res);
      check(nm("hold_tag"),   32'(out_tag),   32'(t.tag));
    endtask

    task automatic run();
      vec_t        vecs[8];
      exp_t        none = '{default: '0};
      logic [31:0] maxp;
      logic        ordy;
      bit          acc;
      int          issued, outs0, accepted, cyc, n;

      maxp = MSB - 32'd1;
      vecs[0] = '{op: 1'b0, a: maxp,  b: 32'd1, tag: 5'd3,  res: MSB,          c: 1'b0, v: 1'b1, z: 1'b0};
      vecs[1] = '{op: 1'b0, a: MASK,  b: 32'd1, tag: 5'd4,  res: 32'd0,        c: 1'b1, v: 1'b0, z: 1'b1};
      vecs[2] = '{op: 1'b1, a: 32'd5, b: 32'd5, tag: 5'd5,  res: 32'd0,        c: 1'b1, v: 1'b0, z: 1'b1};
      vecs[3] = '{op: 1'b1, a: 32'd3, b: 32'd5, tag: 5'd6,  res: MASK - 32'd1, c: 1'b0, v: 1'b0, z: 1'b0};
      vecs[4] = '{op: 1'b1, a: MSB,   b: 32'd1, tag: 5'd7,  res: maxp,         c: 1'b1, v: 1'b1, z: 1'b0};
      vecs[5] = '{op: 1'b0, a: 32'd0, b: 32'd0, tag: 5'd8,  res: 32'd0,        c: 1'b0, v: 1'b0, z: 1'b1};
      vecs[6] = '{op: 1'b0, a: MSB,   b: MSB,   tag: 5'd9,  res: 32'd0,        c: 1'b1, v: 1'b1, z: 1'b1};
      vecs[7] = '{op: 1'b1, a: 32'd0, b: MSB,   tag: 5'd10, res: MSB,          c: 1'b0, v: 1'b1, z: 1'b0};

      idle(1'b1);
      idle(1'b1);
      idle(1'b0);
      check(nm("rst_valid"), 32'(out_valid), 32'd0);
      check(nm("rst_res"),   32'(out_res),   32'd0);
      check(nm("rst_flags"), 32'({out_carry, out_ovf, out_zero}), 32'd0);
      check(nm("rst_tag"),   32'(out_tag),   32'd0);
      check(nm("rst_ready"), 32'(in_ready),  32'd1);

      foreach (vecs[i]) one_op(vecs[i]);

      // Eight ops back to back, consumer stalls in cycles 5..7.
      issued = 0;
      outs0  = outs;
      for (int c = 0; c < 80 && (issued < 8 || q.size() > 0); c++) begin
        ordy = !(c >= 5 && c <= 7);
        step(1'b0, issued < 8, 1'($urandom_range(0, 1)), pick(), pick(), 5'(issued), ordy,
             1'b0, none, acc);
        check(nm("in_ready"), 32'(in_ready), 32'(!out_valid || out_ready));
        if (acc) issued++;
      end
      check(nm("b2b_count"), 32'(outs - outs0), 32'd8);

      // Reset with three ops in flight: all of them must vanish.
      for (int i = 0; i < 3; i++)
        step(1'b0, 1'b1, 1'b0, pick(), pick(), 5'(20 + i), 1'b1, 1'b0, none, acc);
      idle(1'b1);
      q.delete();
      for (int i = 0; i < S + 3; i++) begin
        idle(1'b0);
        check(nm("post_rst_valid"), 32'(out_valid), 32'd0);
      end
      check(nm("post_rst_res"), 32'(out_res), 32'd0);
      one_op(vecs[0]);

      // Random traffic with random source and sink pacing.
      accepted = 0;
      cyc      = 0;
      while (accepted < NOPS && cyc < NOPS * 4) begin
        step(1'b0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), pick(), pick(),
             5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0, 1'b0, none, acc);
        if (acc) accepted++;
        cyc++;
      end
      check(nm("rand_accepted"), 32'(accepted), 32'(NOPS));
      n = 0;
      while (q.size() > 0 && n < S + 10) begin
        idle(1'b0);
        n++;
      end
      check(nm("drain_empty"), 32'(q.size()), 32'd0);
      idle(1'b1);
    endtask
  end

  initial begin
    cfg[0].run();
    cfg[1].run();
    cfg[2].run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: actual time limit reached, required run to complete");
    $fatal(1, "time limit");
  end

endmodule
